// File: rtl/muxn_stream.sv
// N-channel stream multiplexer with fixed or round-robin selection and packet locking.
// Channel words land in a single registered output stage under valid/ready handshakes.
module muxn_stream #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned SEL_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mode,
  input  logic [SEL_WIDTH-1:0]          ctl,
  input  logic [NUM_CH*BUS_WIDTH-1:0]   in_data,
  input  logic [NUM_CH-1:0]             in_valid,
  input  logic [NUM_CH-1:0]             in_last,
  output logic [NUM_CH-1:0]             in_ready,
  output logic [BUS_WIDTH-1:0]          out_data,
  output logic [SEL_WIDTH-1:0]          out_ch,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state;
  logic [SEL_WIDTH-1:0] lock_ch;
  logic [SEL_WIDTH-1:0] last_ch;

  logic [BUS_WIDTH-1:0] ch_data [NUM_CH];
  logic [SEL_WIDTH-1:0] grant;
  logic [SEL_WIDTH-1:0] cand;
  logic                 grant_any;
  logic                 room;
  logic                 xfer;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_data[k] = in_data[k*BUS_WIDTH +: BUS_WIDTH];
  end

  // Grant selection: locked channel wins, else fixed ctl or round-robin search after last_ch.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    cand      = '0;
    if (state == LOCKED) begin
      grant     = lock_ch;
      grant_any = 1'b1;
    end else if (!mode) begin
      if (32'(ctl) < NUM_CH && in_valid[ctl]) begin
        grant     = ctl;
        grant_any = 1'b1;
      end
    end else begin
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
        cand = SEL_WIDTH'((32'(last_ch) + i) % NUM_CH);
        if (!grant_any && in_valid[cand]) begin
          grant     = cand;
          grant_any = 1'b1;
        end
      end
    end
  end

  assign room     = (!out_valid || out_ready) && !rst;
  assign in_ready = (grant_any && room) ? (NUM_CH'(1) << grant) : '0;
  assign xfer     = grant_any && room && in_valid[grant];

  // Output register, packet lock and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lock_ch   <= '0;
      last_ch   <= SEL_WIDTH'(NUM_CH - 1);
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_data  <= ch_data[grant];
      out_ch    <= grant;
      out_last  <= in_last[grant];
      out_valid <= 1'b1;
      last_ch   <= grant;
      lock_ch   <= grant;
      state     <= in_last[grant] ? IDLE : LOCKED;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_muxn_stream.sv
// Self-checking bench for muxn_stream: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_muxn_stream;

  localparam int NCH = 4;
  localparam int BW  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             mode;
  logic [1:0]       ctl;
  logic [NCH*BW-1:0] in_data;
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_last;
  logic [NCH-1:0]   in_ready;
  logic [BW-1:0]    out_data;
  logic [1:0]       out_ch;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  // Three-channel instance held on an out-of-range select.
  logic [3*BW-1:0]  in_data3;
  logic [2:0]       in_ready3;
  logic [BW-1:0]    out_data3;
  logic [1:0]       out_ch3;
  logic             out_last3;
  logic             out_valid3;

  always #5 clk = ~clk;

  muxn_stream #(.BUS_WIDTH(BW), .NUM_CH(NCH), .SEL_WIDTH(2)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .ctl(ctl),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  muxn_stream #(.BUS_WIDTH(BW), .NUM_CH(3), .SEL_WIDTH(2)) u_dut3 (
    .clk(clk), .rst(rst), .mode(1'b0), .ctl(2'd3),
    .in_data(in_data3), .in_valid(3'b111), .in_last(3'b111), .in_ready(in_ready3),
    .out_data(out_data3), .out_ch(out_ch3), .out_last(out_last3),
    .out_valid(out_valid3), .out_ready(1'b1)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         m_lock;
  int         m_rr;
  logic       m_ov;
  logic [7:0] m_od;
  int         m_oc;
  logic       m_ol;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (m_lock >= 0) return m_lock;
    if (!mode) return (int'(ctl) < NCH && in_valid[ctl]) ? int'(ctl) : -1;
    for (int i = 1; i <= NCH; i++) begin
      if (in_valid[(m_rr + i) % NCH]) return (m_rr + i) % NCH;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_lock = -1;
    m_rr   = NCH - 1;
    m_ov   = 1'b0;
    m_od   = '0;
    m_oc   = 0;
    m_ol   = 1'b0;
  endtask

  task automatic check_outputs();
    check("out_valid", out_valid, m_ov);
    check("out_data", out_data, m_od);
    check("out_ch", out_ch, m_oc);
    check("out_last", out_last, m_ol);
    check("in_ready3", in_ready3, 0);
    check("out_valid3", out_valid3, 0);
  endtask

  // One clock: check combinational ready, advance model across the edge, check registers.
  task automatic step();
    int         g;
    logic       room;
    logic       xfer;
    logic [3:0] er;
    logic [7:0] d;
    logic       l;
    #1;
    g    = model_grant();
    room = !m_ov || out_ready;
    er   = (g >= 0 && room) ? 4'(1 << g) : 4'd0;
    check("in_ready", in_ready, er);
    xfer = (g >= 0) && room && in_valid[g];
    d = '0;
    l = 1'b0;
    if (g >= 0) begin
      d = in_data[g*BW +: BW];
      l = in_last[g];
    end
    @(posedge clk);
    #1;
    if (xfer) begin
      m_ov   = 1'b1;
      m_od   = d;
      m_oc   = g;
      m_ol   = l;
      m_rr   = g;
      m_lock = l ? -1 : g;
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_ch(input int k, input logic [7:0] v);
    in_data[k*BW +: BW] = v;
  endtask

  logic [7:0] held;

  initial begin
    rst = 1'b1; mode = 1'b0; ctl = '0; in_data = '0; in_valid = '0; in_last = '0;
    out_ready = 1'b1; in_data3 = 24'hC3B2A1;
    model_reset();
    do_reset();

    // Fixed select, single-word packet on ch2
    mode = 1'b0; ctl = 2'd2; in_valid = 4'b0100; in_last = 4'b0100; set_ch(2, 8'hA5);
    step();
    check("fix_data", out_data, 8'hA5);
    check("fix_ch", out_ch, 2);
    check("fix_last", out_last, 1);
    in_valid = '0;
    step();

    // Round-robin rotation with all channels valid
    do_reset();
    mode = 1'b1; in_valid = 4'hF; in_last = 4'hF;
    for (int i = 0; i < NCH; i++) set_ch(i, 8'(8'h40 + i));
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_ch", out_ch, i % NCH);
      check("rr_valid", out_valid, 1);
    end

    // Packet lock on ch1; mode/ctl toggles mid-packet are ignored
    do_reset();
    mode = 1'b1; in_valid = 4'b0010; in_last = 4'b0000; set_ch(1, 8'h11);
    step();
    check("lock_ch_w1", out_ch, 1);
    in_valid = 4'hF; set_ch(1, 8'h12); mode = 1'b0; ctl = 2'd3;
    step();
    check("lock_ch_w2", out_ch, 1);
    check("lock_data_w2", out_data, 8'h12);
    set_ch(1, 8'h13); in_last = 4'b0010; mode = 1'b1; ctl = 2'd0;
    step();
    check("lock_ch_w3", out_ch, 1);
    check("lock_last_w3", out_last, 1);
    in_last = 4'hF;
    step();
    check("after_lock_ch", out_ch, 2);

    // Backpressure: output must hold while stalled
    out_ready = 1'b0;
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      set_ch(i % NCH, 8'($urandom));
      step();
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, held);
      check("bp_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Reset in the middle of a 4-word ch3 packet
    do_reset();
    mode = 1'b0; ctl = 2'd3; in_valid = 4'b1000; in_last = 4'b0000;
    set_ch(3, 8'hD1);
    step();
    set_ch(3, 8'hD2);
    step();
    check("mid_ch", out_ch, 3);
    #2;
    do_reset();
    mode = 1'b1; in_valid = 4'hF; in_last = 4'hF;
    step();
    check("post_rst_ch", out_ch, 0);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(7) == 0) mode = 1'($urandom);
      ctl       = 2'($urandom);
      in_valid  = 4'($urandom);
      for (int k = 0; k < NCH; k++) in_last[k] = ($urandom_range(2) == 0);
      in_data   = 32'($urandom);
      out_ready = ($urandom_range(3) != 0);
      step();
      if ($urandom_range(199) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
